// File: rtl/line_scan_pkg.sv
// Shared types and default timing constants for the line-scan sequencer.
package line_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RUN,
    ST_BLANK,
    ST_DONE
  } state_e;

  localparam int DEF_DWIDTH    = 8;
  localparam int DEF_ACT_START = 2;
  localparam int DEF_ACT_LEN   = 4;
  localparam int DEF_BLANK_CYC = 3;
  localparam int DEF_N_LINES   = 2;

  // Last counter value that still lies inside the active window.
  function automatic int act_end(input int act_start, input int act_len);
    return act_start + act_len - 1;
  endfunction

  localparam int DEF_ACT_END = act_end(DEF_ACT_START, DEF_ACT_LEN);

endpackage

// File: rtl/line_scan_ctrl_blank_timer.sv
// Load/count/expire down-counter; times line blanking and, when enabled,
// doubles as the RUN-state watchdog.
module blank_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/line_scan_ctrl.sv
// Pixel-counter sequencer: clears/enables the counter per line, frames the
// active window, blanks between lines and flags frame completion.
// Optional RUN watchdog with sticky err: define LINE_SCAN_CTRL_TIMEOUT_EN.
module line_scan_ctrl
  import line_scan_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int ACT_START = DEF_ACT_START,
  parameter int ACT_LEN   = DEF_ACT_LEN,
  parameter int BLANK_CYC = DEF_BLANK_CYC,
  parameter int N_LINES   = DEF_N_LINES,
  parameter int LWIDTH    = $clog2(N_LINES) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DWIDTH-1:0] cnt_val,
  output logic              cnt_clr,
  output logic              cnt_en,
  output logic              pix_valid,
  output logic [LWIDTH-1:0] line_idx,
  output logic              line_done,
  output logic              frame_done,
  output logic              busy,
  output logic              err
);

  localparam logic [DWIDTH-1:0] ACT_START_V = DWIDTH'(ACT_START);
  localparam logic [DWIDTH-1:0] ACT_END_V   = DWIDTH'(act_end(ACT_START, ACT_LEN));
  localparam logic [LWIDTH-1:0] LAST_LINE   = LWIDTH'(N_LINES - 1);
  // Timer must hold both BLANK_CYC-1 and the watchdog reload 2^DWIDTH-1.
  localparam int TW = ($clog2(BLANK_CYC) > DWIDTH) ? $clog2(BLANK_CYC) : DWIDTH;

  state_e            state_q, state_d;
  logic [LWIDTH-1:0] line_idx_q, line_idx_d;
  logic              tmr_load, tmr_dec, tmr_expired;
  logic [TW-1:0]     tmr_val;
  logic              win_end;
  logic              wdog_trip;

  assign win_end = (state_q == ST_RUN) && (cnt_val == ACT_END_V);

`ifdef LINE_SCAN_CTRL_TIMEOUT_EN
  logic err_q, err_d;

  assign wdog_trip = (state_q == ST_RUN) && !win_end && tmr_expired;

  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && start && !abort) begin
      err_d = 1'b0;
    end else if (wdog_trip && !abort) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wdog_trip = 1'b0;
  assign err       = 1'b0;
`endif

  // The window end reloads the timer for blanking; SYNC arms the watchdog.
  always_comb begin
    tmr_load = win_end;
    tmr_val  = TW'(BLANK_CYC - 1);
    tmr_dec  = (state_q == ST_BLANK);
`ifdef LINE_SCAN_CTRL_TIMEOUT_EN
    if (state_q == ST_SYNC) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(2 ** DWIDTH - 1);
    end
    if (state_q == ST_RUN) begin
      tmr_dec = 1'b1;
    end
`endif
  end

  blank_timer #(
    .W(TW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    line_idx_d = line_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SYNC;
          line_idx_d = '0;
        end
      end
      ST_SYNC: state_d = ST_RUN;
      ST_RUN: begin
        if (win_end) begin
          state_d = ST_BLANK;
        end else if (wdog_trip) begin
          state_d    = ST_IDLE;
          line_idx_d = '0;
        end
      end
      ST_BLANK: begin
        if (tmr_expired) begin
          if (line_idx_q == LAST_LINE) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_SYNC;
            line_idx_d = line_idx_q + LWIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        line_idx_d = '0;
      end
      default: begin
        state_d    = ST_IDLE;
        line_idx_d = '0;
      end
    endcase
    if (abort) begin
      state_d    = ST_IDLE;
      line_idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      line_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      line_idx_q <= line_idx_d;
    end
  end

  assign cnt_clr    = (state_q == ST_SYNC);
  assign cnt_en     = (state_q == ST_RUN);
  assign pix_valid  = (state_q == ST_RUN) && (cnt_val >= ACT_START_V) && (cnt_val <= ACT_END_V);
  assign line_done  = win_end && !abort;
  assign frame_done = (state_q == ST_DONE) && !abort;
  assign busy       = (state_q != ST_IDLE);
  assign line_idx   = line_idx_q;

endmodule

// File: tb/tb_line_scan_ctrl.sv
// Self-checking bench for line_scan_ctrl: frame-timeline model plus directed checks.
module tb_line_scan_ctrl;

  localparam int DW      = 8;
  localparam int AS      = 2;
  localparam int AL      = 4;
  localparam int BC      = 3;
  localparam int NL      = 2;
  localparam int LW      = $clog2(NL) + 1;
  localparam int AE      = AS + AL - 1;
  localparam int P       = 1 + (AE + 1) + BC;  // cycles per line: clear, count 0..AE, blank
  localparam int FRAME_T = NL * P;             // frame offset of the completion cycle

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] cnt_val = '0;
  logic          cnt_clr, cnt_en, pix_valid, line_done, frame_done, busy, err;
  logic [LW-1:0] line_idx;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b1;
  bit freeze = 1'b0;
  bit wd_expect = 1'b0;

  bit m_active = 1'b0;
  int m_t = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  line_scan_ctrl #(
    .DWIDTH(DW), .ACT_START(AS), .ACT_LEN(AL), .BLANK_CYC(BC), .N_LINES(NL), .LWIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cnt_val(cnt_val),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en), .pix_valid(pix_valid), .line_idx(line_idx),
    .line_done(line_done), .frame_done(frame_done), .busy(busy), .err(err)
  );

  // Pixel counter driven by the DUT's clear/enable.
  always @(posedge clk) begin
    if (freeze) cnt_val <= '0;
    else if (cnt_clr) cnt_val <= '0;
    else if (cnt_en) cnt_val <= cnt_val + 8'd1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is just an offset into a fixed timeline.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_err    <= 1'b0;
    end else if (!chk_en) begin
      m_err <= wd_expect;
    end else if (abort) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_err    <= 1'b0;
      end
    end else if (m_t == FRAME_T) begin
      m_active <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin : cmp
    int e_clr, e_en, e_pix, e_ld, e_fd, e_busy, e_li, p, c;
    if (chk_en) begin
      e_clr = 0; e_en = 0; e_pix = 0; e_ld = 0; e_fd = 0; e_busy = 0; e_li = 0; c = -1;
      if (m_active) begin
        e_busy = 1;
        if (m_t == FRAME_T) begin
          e_li = NL - 1;
          e_fd = !abort;
        end else begin
          e_li = m_t / P;
          p    = m_t % P;
          if (p == 0) begin
            e_clr = 1;
          end else if (p <= AE + 1) begin
            e_en  = 1;
            c     = p - 1;
            e_pix = (c >= AS) && (c <= AE);
            e_ld  = (c == AE) && !abort;
          end
        end
      end
      check("cnt_clr", cnt_clr, e_clr);
      check("cnt_en", cnt_en, e_en);
      check("pix_valid", pix_valid, e_pix);
      check("line_done", line_done, e_ld);
      check("frame_done", frame_done, e_fd);
      check("busy", busy, e_busy);
      check("line_idx", line_idx, e_li);
      check("err", err, m_err);
      if (c >= 0) check("cnt_val", cnt_val, c);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One frame from a start pulse; optionally re-asserts start mid-frame.
  task automatic run_frame(input bit hold, input string tag);
    int n, n_pix, n_pix0, n_clr, n_ld;
    n = 1; n_pix = 0; n_pix0 = 0; n_clr = 0; n_ld = 0;
    pulse_start();
    forever begin
      @(negedge clk);
      if (pix_valid) begin
        n_pix++;
        if (line_idx == 0) n_pix0++;
      end
      if (cnt_clr) n_clr++;
      if (line_done) begin
        n_ld++;
        check({tag, " cnt_val at line_done"}, cnt_val, 5);
      end
      if (frame_done) break;
      if (n >= 100) begin
        check({tag, " frame_done timeout"}, 0, 1);
        break;
      end
      tick();
      n++;
      if (hold && n == 4) start = 1'b1;
      if (hold && n == 14) start = 1'b0;
    end
    check({tag, " frame cycles"}, n, 21);
    check({tag, " pix line0"}, n_pix0, 4);
    check({tag, " pix total"}, n_pix, 8);
    check({tag, " cnt_clr pulses"}, n_clr, 2);
    check({tag, " line_done pulses"}, n_ld, 2);
    $display("frame %s: cycles=%0d pix=%0d clr=%0d line_done=%0d", tag, n, n_pix, n_clr, n_ld);
    tick();
    check({tag, " busy after done"}, busy, 0);
  endtask

  initial begin
    int n, n_fd, n_run;
    repeat (2) tick();
    check("reset busy", busy, 0);
    check("reset cnt_clr", cnt_clr, 0);
    check("reset cnt_en", cnt_en, 0);
    check("reset line_idx", line_idx, 0);
    check("reset err", err, 0);
    $display("reset: busy=%0d cnt_en=%0d line_idx=%0d", busy, cnt_en, line_idx);
    rst = 1'b1;
    repeat (3) tick();

    run_frame(1'b0, "basic");
    run_frame(1'b1, "start_held");
    run_frame(1'b0, "restart");

    // Abort in line 1 at cnt_val=3.
    pulse_start();
    n = 0;
    while (!(line_idx == 1 && cnt_val == 3 && cnt_en) && n < 100) begin
      tick();
      n++;
    end
    check("abort reach point", n < 100, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort cnt_en", cnt_en, 0);
    check("abort line_idx", line_idx, 0);
    n_fd = 0;
    repeat (30) begin
      @(negedge clk);
      if (frame_done) n_fd++;
    end
    check("abort no frame_done", n_fd, 0);
    $display("abort: after %0d cycles, frame_done seen=%0d", n, n_fd);

    // Reset during the second line's blanking.
    pulse_start();
    n = 0;
    while (!(busy && !cnt_en && !cnt_clr && !frame_done && line_idx == 1) && n < 100) begin
      tick();
      n++;
    end
    check("rst reach blank", n < 100, 1);
    #2 rst = 1'b0;
    #1;
    check("rst busy", busy, 0);
    check("rst line_idx", line_idx, 0);
    check("rst cnt_en", cnt_en, 0);
    check("rst cnt_clr", cnt_clr, 0);
    check("rst pix_valid", pix_valid, 0);
    check("rst frame_done", frame_done, 0);
    $display("async reset mid-blank: busy=%0d line_idx=%0d", busy, line_idx);
    repeat (2) tick();
    rst = 1'b1;
    repeat (5) tick();
    check("post-rst idle", busy, 0);
    run_frame(1'b0, "after_rst");

`ifdef LINE_SCAN_CTRL_TIMEOUT_EN
    chk_en = 1'b0;
    freeze = 1'b1;
    pulse_start();
    n_run = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (cnt_en) n_run++;
      if (!busy || n >= 600) break;
      tick();
      n++;
    end
    check("timeout run cycles", n_run, 256);
    check("timeout busy", busy, 0);
    check("timeout err", err, 1);
    $display("timeout: run cycles=%0d err=%0d", n_run, err);
    tick();
    wd_expect = 1'b1;
    freeze = 1'b0;
    repeat (2) tick();
    chk_en = 1'b1;
    check("err sticky", err, 1);
    run_frame(1'b0, "err_clear");
    check("err cleared", err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_scan_ctrl.md
Name: line_scan_ctrl

Overview:
- Sequences the per-line pixel counter (clear/enable, DWIDTH-wide) for the sensor readout path.
- Frames a programmable active-pixel window inside each line, inserts blanking between lines, counts lines and reports frame completion.
- Sits between the readout top-level start/abort controls and the pixel counter. It replaces the raw HSYNC-driven clear with a sequenced one.

Parameters:
- DWIDTH, 8, width of the pixel counter value.
- ACT_START, 2, first counter value inside the active window.
- ACT_LEN, 4, number of active pixels per line (>=1; ACT_START+ACT_LEN-1 < 2^DWIDTH).
- BLANK_CYC, 3, idle cycles between lines (>=1).
- N_LINES, 2, lines per frame (>=1).
- LWIDTH, $clog2(N_LINES)+1, line index width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  frame start request; sampled in IDLE only.
- abort  in  1  synchronous abort, any state.
- cnt_val  in  DWIDTH  current pixel counter value.
- cnt_clr  out  1  counter clear (one cycle per line).
- cnt_en  out  1  counter count enable.
- pix_valid  out  1  cnt_val is inside the active window.
- line_idx  out  LWIDTH  current line number, 0-based.
- line_done  out  1  one-cycle pulse at the end of each line's window.
- frame_done  out  1  one-cycle pulse after the last line's blanking.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag (see Optional Feature).

Behaviour:
- Reset (rst=0): state=IDLE, all outputs 0, line_idx=0, blank counter=0.
- States: IDLE, SYNC, RUN, BLANK, DONE. Moore outputs decode registered state, except pix_valid, which is combinational from state and cnt_val.
- IDLE: if start=1 and abort=0, go to SYNC next cycle and set line_idx=0.
- SYNC: cnt_clr=1 for exactly one cycle, cnt_en=0. Go to RUN.
- RUN:
  - cnt_en=1.
  - pix_valid=1 iff ACT_START <= cnt_val <= ACT_START+ACT_LEN-1.
  - When cnt_val == ACT_START+ACT_LEN-1: line_done=1 in that same cycle, and the next state is BLANK.
- BLANK:
  - cnt_en=0. Internal counter runs 0..BLANK_CYC-1.
  - On the last count: if line_idx == N_LINES-1, go to DONE; otherwise line_idx+1 and go to SYNC.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- busy=1 in SYNC/RUN/BLANK/DONE.
- start while busy: ignored, no queueing.
- abort=1: next state is IDLE regardless of current state; line_idx cleared; no line_done/frame_done generated that cycle. abort has priority over start in IDLE.
- Async reset mid-frame: immediate return to the reset values above.
- Window comparisons are unsigned, DWIDTH bits. The counter is never expected to wrap inside RUN.
- Latency:
  - start to first cnt_clr: 1 cycle.
  - Last active pixel to the next line's cnt_clr: BLANK_CYC+1 cycles.

Optional Feature:
- Macro: LINE_SCAN_CTRL_TIMEOUT_EN.
- Defined: a watchdog counts cycles in RUN. If it reaches 2^DWIDTH without hitting the window end (counter stuck), the FSM goes to IDLE and err is set high. err stays high until reset or the next accepted start.
- Undefined: no watchdog logic; err tied to 0.

Decomposition:
- Shared package line_scan_pkg holds:
  - the state enum (IDLE/SYNC/RUN/BLANK/DONE);
  - localparam ACT_END = ACT_START+ACT_LEN-1 helper function;
  - the default timing constants.
- One sub-module, blank_timer: a load/count/expire down-counter used for BLANK and reused as the watchdog when enabled.

Test Plan (defaults):
- Reset then start pulse: cnt_clr high for 1 cycle, then cnt_en high. With the counter model, pix_valid is high for cnt_val=2..5 (4 cycles), line_done is high at cnt_val=5, and line_idx=0.
- Full frame: two lines with 3-cycle gaps of cnt_en=0, line_idx 0 then 1. frame_done pulses once, busy falls in the same cycle as DONE exits, and total time is deterministic.
- start held high during RUN: no restart; frame completes normally. Re-issuing start after IDLE begins a new frame.
- abort asserted at cnt_val=3 in line 1: next cycle state is IDLE, cnt_en=0, line_idx=0, and no frame_done.
- rst pulled low mid-BLANK: all outputs 0 asynchronously. After release, the block stays IDLE until start.
- TIMEOUT_EN defined, counter model frozen at 0: after 256 RUN cycles the block returns to IDLE with err=1. The next start clears err.
